dec_scan_sequencer: RTL and testbench



---
 rtl/dec_scan_pkg.sv | 15 +
 rtl/dec_scan_next_idx.sv | 27 ++
 rtl/dec_scan_sequencer.sv | 146 ++++++++++++++
 tb/tb_dec_scan_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dec_scan_pkg.sv
// Shared types and constants for the 3-to-8 decoder scan sequencer.
// Enable levels are packed as {g1, g2a_n, g2b_n}.
package dec_scan_pkg;
  localparam int NUM_LINES = 8;
  localparam int SEL_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [2:0] EN_ON  = 3'b100;
  localparam logic [2:0] EN_OFF = 3'b011;
endpackage

// File: rtl/dec_scan_next_idx.sv
// Next-set-bit finder: lowest mask bit strictly above cur, plus lowest set bit overall.
// Purely combinational, zero latency; no flow control.
import dec_scan_pkg::*;

module dec_scan_next_idx (
  input  logic [NUM_LINES-1:0] mask,
  input  logic [SEL_W-1:0]     cur,
  output logic [SEL_W-1:0]     nxt,
  output logic                 found,
  output logic [SEL_W-1:0]     first
);
  // Descending walk so the lowest qualifying index is the last one written.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    first = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = SEL_W'(i);
        if (SEL_W'(i) > cur) begin
          nxt   = SEL_W'(i);
          found = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/dec_scan_sequencer.sv
// Scans masked decoder lines with programmable dwell and a 1-cycle gap; outputs registered, 1-cycle start latency.
// start is ignored while busy, stop aborts any cycle; DEC_SCAN_FEEDBACK_CHECK_EN adds dec_y_n/fb_err checking.
import dec_scan_pkg::*;

module dec_scan_sequencer #(
  parameter int DWELL_W   = 8,
  parameter int NUM_LINES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic [NUM_LINES-1:0] mask,
  input  logic [DWELL_W-1:0]   dwell,
`ifdef DEC_SCAN_FEEDBACK_CHECK_EN
  input  logic [NUM_LINES-1:0] dec_y_n,
  output logic                 fb_err,
`endif
  output logic [SEL_W-1:0]     sel,
  output logic                 g1,
  output logic                 g2a_n,
  output logic                 g2b_n,
  output logic                 busy,
  output logic                 done
);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [NUM_LINES-1:0] lmask_q, lmask_d;
  logic [DWELL_W-1:0]   ldwell_q, ldwell_d;
  logic                 lcont_q, lcont_d;
  logic [2:0]           en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [NUM_LINES-1:0] lk_mask;
  logic [SEL_W-1:0]     lk_nxt, lk_first;
  logic                 lk_found;

  // In IDLE the lookup sees the live mask so the first line is known at start.
  assign lk_mask = (state_q == IDLE) ? mask : lmask_q;

  dec_scan_next_idx u_next_idx (
    .mask  (lk_mask),
    .cur   (sel_q),
    .nxt   (lk_nxt),
    .found (lk_found),
    .first (lk_first)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      lmask_q  <= '0;
      ldwell_q <= '0;
      lcont_q  <= 1'b0;
      en_q     <= EN_OFF;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      lmask_q  <= lmask_d;
      ldwell_q <= ldwell_d;
      lcont_q  <= lcont_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    lmask_d  = lmask_q;
    ldwell_d = ldwell_q;
    lcont_d  = lcont_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop && (mask != '0)) begin
          lmask_d  = mask;
          ldwell_d = dwell;
          lcont_d  = continuous;
          sel_d    = lk_first;
          cnt_d    = dwell;
          state_d  = DWELL;
        end
      end
      DWELL: begin
        if (stop)                state_d = IDLE;
        else if (cnt_q == '0)    state_d = GAP;
        else                     cnt_d   = cnt_q - DWELL_W'(1);
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (lk_found) begin
          sel_d   = lk_nxt;
          cnt_d   = ldwell_q;
          state_d = DWELL;
        end else if (lcont_q) begin
          sel_d   = lk_first;
          cnt_d   = ldwell_q;
          state_d = DWELL;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    en_d   = (state_d == DWELL) ? EN_ON : EN_OFF;
    busy_d = (state_d != IDLE);
  end

  assign sel               = sel_q;
  assign {g1, g2a_n, g2b_n} = en_q;
  assign busy              = busy_q;
  assign done              = done_q;

`ifdef DEC_SCAN_FEEDBACK_CHECK_EN
  logic [NUM_LINES-1:0] exp_y_n;
  logic                 fb_err_q;

  always_comb begin
    exp_y_n = '1;
    if (state_q == DWELL) exp_y_n = ~(NUM_LINES'(1) << sel_q);
  end

  // Sticky until the next accepted start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       fb_err_q <= 1'b0;
    else if (state_q == IDLE && state_d == DWELL)     fb_err_q <= 1'b0;
    else if (state_q != IDLE && dec_y_n != exp_y_n)   fb_err_q <= 1'b1;
  end

  assign fb_err = fb_err_q;
`endif
endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Bench for dec_scan_sequencer: per-cycle trace model (line list expanded into expected cycles),
// directed table vectors, hand-written corner sequences and randomized traffic.
module tb_dec_scan_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [7:0] mask = 8'h00, dwell = 8'h00;
  logic [2:0] sel;
  logic       g1, g2a_n, g2b_n, busy, done;

  always #5 clk = ~clk;

`ifdef DEC_SCAN_FEEDBACK_CHECK_EN
  logic [7:0] dec_y_n;
  logic [7:0] fb_flip = 8'h00;
  logic       fb_err;
  assign dec_y_n = ((g1 && !g2a_n && !g2b_n) ? ~(8'h01 << sel) : 8'hFF) & ~fb_flip;
`endif

  dec_scan_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .mask       (mask),
    .dwell      (dwell),
`ifdef DEC_SCAN_FEEDBACK_CHECK_EN
    .dec_y_n    (dec_y_n),
    .fb_err     (fb_err),
`endif
    .sel        (sel),
    .g1         (g1),
    .g2a_n      (g2a_n),
    .g2b_n      (g2b_n),
    .busy       (busy),
    .done       (done)
  );

  // One expected output cycle: busy, enables on, sel, done.
  typedef struct packed {
    logic       busy;
    logic       on;
    logic [2:0] sel;
    logic       done;
  } obs_t;

  obs_t       cur;
  obs_t       expq[$];
  logic [7:0] m_mask, m_dwell;
  logic       m_cont;
  int         total = 0, bad = 0;
  int         busy_cnt, done_cnt;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] dwell;
    logic       cont;
    int         ncyc;
    int         stop_at;
    int         exp_busy;
    int         exp_done;
  } vec_t;
  vec_t tbl[7];

  // One full pass as a list of output cycles: dwell+1 on-cycles per set line, then a gap.
  function automatic void push_pass();
    logic [2:0] last;
    last = 3'd0;
    for (int l = 0; l < 8; l++) begin
      if (m_mask[l]) begin
        for (int k = 0; k <= int'(m_dwell); k++) expq.push_back(obs_t'({1'b1, 1'b1, 3'(l), 1'b0}));
        expq.push_back(obs_t'({1'b1, 1'b0, 3'(l), 1'b0}));
        last = 3'(l);
      end
    end
    if (!m_cont) expq.push_back(obs_t'({1'b0, 1'b0, last, 1'b1}));
  endfunction

  function automatic void model_step(input logic s, input logic p, input logic c,
                                     input logic [7:0] mk, input logic [7:0] dw);
    if (!cur.busy) begin
      if (s && !p && mk != 8'h00) begin
        m_mask = mk; m_dwell = dw; m_cont = c;
        expq.delete();
        push_pass();
        cur = expq.pop_front();
      end else begin
        cur = obs_t'({1'b0, 1'b0, cur.sel, 1'b0});
      end
    end else if (p) begin
      expq.delete();
      cur = obs_t'({1'b0, 1'b0, cur.sel, 1'b0});
    end else begin
      if (expq.size() == 0) push_pass();
      cur = expq.pop_front();
    end
  endfunction

  task automatic check(input string nm);
    logic [7:0] act, want;
    act  = {busy, g1, g2a_n, g2b_n, sel, done};
    want = {cur.busy, cur.on, !cur.on, !cur.on, cur.sel, cur.done};
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t got busy=%b g1=%b g2a_n=%b g2b_n=%b sel=%0d done=%b want busy=%b g1=%b g2a_n=%b g2b_n=%b sel=%0d done=%b",
               nm, $time, act[7], act[6], act[5], act[4], act[3:1], act[0],
               want[7], want[6], want[5], want[4], want[3:1], want[0]);
    end
  endtask

  task automatic cmp_int(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  task automatic cyc(input logic s, input logic p, input logic c,
                     input logic [7:0] mk, input logic [7:0] dw);
    start = s; stop = p; continuous = c; mask = mk; dwell = dw;
    model_step(s, p, c, mk, dw);
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
    check("trace");
    busy_cnt += int'(busy);
    done_cnt += int'(done);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 8'd2,   1'b0, 22,  -1, 16,  1};
    tbl[1] = '{8'h81, 8'd0,   1'b1, 10,   5, 5,   0};
    tbl[2] = '{8'h00, 8'd3,   1'b0, 4,   -1, 0,   0};
    tbl[3] = '{8'hFF, 8'd1,   1'b0, 4,    0, 0,   0};
    tbl[4] = '{8'h10, 8'd255, 1'b0, 262, -1, 257, 1};
    tbl[5] = '{8'h01, 8'd0,   1'b1, 6,   -1, 6,   0};
    tbl[6] = '{8'h80, 8'd3,   1'b0, 8,   -1, 5,   1};

    cur = '0;
    #12;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      busy_cnt = 0; done_cnt = 0;
      for (int c = 0; c < tbl[v].ncyc; c++)
        cyc(c == 0, c == tbl[v].stop_at, tbl[v].cont, tbl[v].mask, tbl[v].dwell);
      cmp_int($sformatf("vec%0d_busy", v), busy_cnt, tbl[v].exp_busy);
      cmp_int($sformatf("vec%0d_done", v), done_cnt, tbl[v].exp_done);
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    end

    // Restart attempt with different settings while a scan is running.
    busy_cnt = 0; done_cnt = 0;
    cyc(1'b1, 1'b0, 1'b0, 8'h06, 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 8'h06, 8'd1);
    cyc(1'b1, 1'b0, 1'b1, 8'hFF, 8'd0);
    repeat (10) cyc(1'b0, 1'b0, 1'b1, 8'hFF, 8'd0);
    cmp_int("busy_restart_busy", busy_cnt, 6);
    cmp_int("busy_restart_done", done_cnt, 1);

    // Asynchronous reset while dwelling on line 5.
    cyc(1'b1, 1'b0, 1'b0, 8'h21, 8'd3);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 8'h21, 8'd3);
    cmp_int("pre_reset_sel", int'(sel), 5);
    #2;
    rst_n = 1'b0;
    #1;
    expq.delete();
    cur = '0;
    check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    for (int it = 0; it < 30; it++) begin
      for (int n = 0; n < 30; n++) begin
        cyc(($urandom % 6) == 0, ($urandom % 25) == 0, 1'($urandom % 2),
            (($urandom % 5) == 0) ? 8'h00 : 8'($urandom), 8'($urandom_range(0, 4)));
      end
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);

`ifdef DEC_SCAN_FEEDBACK_CHECK_EN
    cmp_int("fb_clean", int'(fb_err), 0);
    cyc(1'b1, 1'b0, 1'b0, 8'h03, 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 8'h03, 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 8'h03, 8'd1);
    fb_flip = 8'h08;
    cyc(1'b0, 1'b0, 1'b0, 8'h03, 8'd1);
    fb_flip = 8'h00;
    cmp_int("fb_set", int'(fb_err), 1);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 8'h03, 8'd1);
    cmp_int("fb_sticky", int'(fb_err), 1);
    cyc(1'b1, 1'b0, 1'b0, 8'h01, 8'd0);
    cmp_int("fb_clear", int'(fb_err), 0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
